// File: rtl/npc_predictor.sv
// npc_predictor
//    Next-PC unit for the IF stage. Holds the architectural fetch PC, predicts
//    the next fetch address from a direct-mapped branch target buffer with
//    2-bit saturating direction counters, resolves JUMP/BRANCH/JR in EX,
//    redirects and flushes on a mispredict, and trains the BTB from EX.
//
// Ports
//    clk            : clock, all state updates on the rising edge
//    rst            : synchronous active-high reset
//    stall          : hold the PC (IF not accepting a new fetch)
//    pc             : current fetch address (registered)
//    pred_taken     : BTB predicts pc is a taken control transfer
//    pred_target    : predicted next PC (BTB target or pc+4)
//    ex_valid       : EX holds a real instruction
//    ex_pc          : PC of the EX instruction
//    ex_npc_op      : 00 SEQ, 01 JUMP, 10 BRANCH, 11 JR
//    ex_imm16       : branch word offset
//    ex_imm26       : jump index
//    ex_reg_target  : register value used by JR
//    ex_cond        : branch condition true
//    ex_pred_target : pred_target that travelled with the EX instruction
//    flush          : squash IF/ID this cycle
module npc_predictor #(
   parameter int unsigned      WIDTH     = 32,
   parameter int unsigned      BTB_DEPTH = 16,
   parameter logic [WIDTH-1:0] RESET_PC  = 32'h0000_3000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   output logic [WIDTH-1:0] pc,
   output logic             pred_taken,
   output logic [WIDTH-1:0] pred_target,
   input  logic             ex_valid,
   input  logic [WIDTH-1:0] ex_pc,
   input  logic [1:0]       ex_npc_op,
   input  logic [15:0]      ex_imm16,
   input  logic [25:0]      ex_imm26,
   input  logic [WIDTH-1:0] ex_reg_target,
   input  logic             ex_cond,
   input  logic [WIDTH-1:0] ex_pred_target,
   output logic             flush
);

   localparam int unsigned IDX   = $clog2(BTB_DEPTH);
   localparam int unsigned TAG_W = WIDTH - IDX - 2;

   typedef enum logic [1:0] {
      OP_SEQ    = 2'b00,
      OP_JUMP   = 2'b01,
      OP_BRANCH = 2'b10,
      OP_JR     = 2'b11
   } npc_op_e;

   // BTB storage; only the valid bits are reset
   logic [BTB_DEPTH-1:0] btb_valid;
   logic [TAG_W-1:0]     btb_tag    [BTB_DEPTH];
   logic [WIDTH-1:0]     btb_target [BTB_DEPTH];
   logic [1:0]           btb_ctr    [BTB_DEPTH];

   // IF lookup
   logic [IDX-1:0]   if_idx;
   logic [TAG_W-1:0] if_tag;
   logic             if_hit;

   assign if_idx = pc[IDX+1:2];
   assign if_tag = pc[WIDTH-1:IDX+2];
   assign if_hit = btb_valid[if_idx] && (btb_tag[if_idx] == if_tag);

   assign pred_taken  = !rst && if_hit && btb_ctr[if_idx][1];
   assign pred_target = pred_taken ? btb_target[if_idx] : pc + WIDTH'(4);

   // EX resolution
   npc_op_e          ex_op;
   logic [WIDTH-1:0] ex_pc4;
   logic [WIDTH-1:0] ex_br_off;
   logic [WIDTH-1:0] ex_actual;
   logic             mispredict;

   assign ex_op     = npc_op_e'(ex_npc_op);
   assign ex_pc4    = ex_pc + WIDTH'(4);
   assign ex_br_off = {{(WIDTH-18){ex_imm16[15]}}, ex_imm16, 2'b00};

   always_comb begin
      ex_actual = ex_pc4;
      case (ex_op)
         OP_JUMP:   ex_actual = {ex_pc4[WIDTH-1:28], ex_imm26, 2'b00};
         OP_BRANCH: ex_actual = ex_cond ? ex_pc4 + ex_br_off : ex_pc4;
         OP_JR:     ex_actual = ex_reg_target;
         default:   ex_actual = ex_pc4;
      endcase
   end

   assign mispredict = ex_valid && (ex_actual != ex_pred_target);
   assign flush      = !rst && mispredict;

   // BTB training decision
   logic [IDX-1:0]   ex_idx;
   logic [TAG_W-1:0] ex_tag;
   logic             ex_hit;
   logic [1:0]       ex_ctr;
   logic             wr_en;
   logic             wr_tgt_en;
   logic [1:0]       wr_ctr;

   assign ex_idx = ex_pc[IDX+1:2];
   assign ex_tag = ex_pc[WIDTH-1:IDX+2];
   assign ex_hit = btb_valid[ex_idx] && (btb_tag[ex_idx] == ex_tag);
   assign ex_ctr = btb_ctr[ex_idx];

   // SEQ never trains, even on an aliased mispredict: the redirect fixes it
   always_comb begin
      wr_en     = 1'b0;
      wr_tgt_en = 1'b0;
      wr_ctr    = '0;
      if (ex_valid && !rst) begin
         case (ex_op)
            OP_JUMP, OP_JR: begin
               wr_en     = 1'b1;
               wr_tgt_en = 1'b1;
               wr_ctr    = 2'b11;
            end
            OP_BRANCH: begin
               if (ex_cond) begin
                  wr_en     = 1'b1;
                  wr_tgt_en = 1'b1;
                  if (!ex_hit)
                     wr_ctr = 2'b10;
                  else
                     wr_ctr = (ex_ctr == 2'b11) ? 2'b11 : ex_ctr + 2'd1;
               end else if (ex_hit) begin
                  wr_en  = 1'b1;
                  wr_ctr = (ex_ctr == 2'b00) ? 2'b00 : ex_ctr - 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         btb_valid <= '0;
      else if (wr_en)
         btb_valid[ex_idx] <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         btb_tag[ex_idx] <= ex_tag;
         btb_ctr[ex_idx] <= wr_ctr;
         if (wr_tgt_en)
            btb_target[ex_idx] <= ex_actual;
      end
   end

   // PC register: redirect overrides stall
   always_ff @(posedge clk) begin
      if (rst)
         pc <= RESET_PC;
      else if (mispredict)
         pc <= ex_actual;
      else if (!stall)
         pc <= pred_target;
   end

endmodule

// File: tb/tb_npc_predictor.sv
module tb_npc_predictor;

   localparam logic [1:0] SEQ    = 2'b00;
   localparam logic [1:0] JUMP   = 2'b01;
   localparam logic [1:0] BRANCH = 2'b10;
   localparam logic [1:0] JR     = 2'b11;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic [31:0] pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic [1:0]  ex_npc_op;
   logic [15:0] ex_imm16;
   logic [25:0] ex_imm26;
   logic [31:0] ex_reg_target;
   logic        ex_cond;
   logic [31:0] ex_pred_target;
   logic        flush;

   int n_cmp = 0;
   int n_err = 0;

   npc_predictor #(.WIDTH(32), .BTB_DEPTH(16), .RESET_PC(32'h0000_3000)) dut (
      .clk(clk), .rst(rst), .stall(stall), .pc(pc),
      .pred_taken(pred_taken), .pred_target(pred_target),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_npc_op(ex_npc_op),
      .ex_imm16(ex_imm16), .ex_imm26(ex_imm26), .ex_reg_target(ex_reg_target),
      .ex_cond(ex_cond), .ex_pred_target(ex_pred_target), .flush(flush)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ex(input logic v, input logic [31:0] p, input logic [1:0] op,
                         input logic [15:0] i16, input logic [25:0] i26,
                         input logic [31:0] rt, input logic c, input logic [31:0] pt);
      ex_valid = v; ex_pc = p; ex_npc_op = op; ex_imm16 = i16; ex_imm26 = i26;
      ex_reg_target = rt; ex_cond = c; ex_pred_target = pt;
      #1;
   endtask

   task automatic clear_ex();
      set_ex(1'b0, '0, SEQ, '0, '0, '0, 1'b0, '0);
   endtask

   // redirect fetch to 'target' with a SEQ at target-4 and a wrong prediction
   task automatic seq_redirect(input logic [31:0] target);
      set_ex(1'b1, target - 32'd4, SEQ, '0, '0, '0, 1'b0, 32'h0000_0001);
      tick();
      clear_ex();
   endtask

   task automatic test_reset();
      stall = 1'b0;
      rst = 1'b1;
      set_ex(1'b1, 32'h0000_3000, JR, '0, '0, 32'h0000_5000, 1'b0, 32'h0000_3004);
      n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL reset_flush: got %0b want 0", flush); end
      tick();
      n_cmp++; if (pc !== 32'h0000_3000) begin n_err++; $display("FAIL reset_pc: got %h want 00003000", pc); end
      n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL reset_pred_taken: got %0b want 0", pred_taken); end
      rst = 1'b0;
      clear_ex();
      tick(); tick(); tick();
      n_cmp++; if (pc !== 32'h0000_300C) begin n_err++; $display("FAIL reset_seq3: got %h want 0000300c", pc); end
      n_cmp++; if (pred_target !== 32'h0000_3010) begin n_err++; $display("FAIL reset_pred_target: got %h want 00003010", pred_target); end
   endtask

   task automatic test_cold_branch();
      set_ex(1'b1, 32'h0000_3004, BRANCH, 16'hFFFE, '0, '0, 1'b1, 32'h0000_3008);
      n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL cold_flush: got %0b want 1", flush); end
      tick();
      clear_ex();
      n_cmp++; if (pc !== 32'h0000_3000) begin n_err++; $display("FAIL cold_redirect: got %h want 00003000", pc); end
      tick();
      n_cmp++; if (pc !== 32'h0000_3004) begin n_err++; $display("FAIL cold_seq: got %h want 00003004", pc); end
      n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL cold_pred_taken: got %0b want 1", pred_taken); end
      n_cmp++; if (pred_target !== 32'h0000_3000) begin n_err++; $display("FAIL cold_pred_target: got %h want 00003000", pred_target); end
   endtask

   task automatic test_hysteresis();
      // not taken once: ctr 10 -> 01
      set_ex(1'b1, 32'h0000_3004, BRANCH, 16'hFFFE, '0, '0, 1'b0, 32'h0000_3000);
      n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL hyst_nt_flush: got %0b want 1", flush); end
      tick();
      clear_ex();
      n_cmp++; if (pc !== 32'h0000_3008) begin n_err++; $display("FAIL hyst_nt_pc: got %h want 00003008", pc); end
      seq_redirect(32'h0000_3004);
      n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL hyst_ctr01_taken: got %0b want 0", pred_taken); end
      n_cmp++; if (pred_target !== 32'h0000_3008) begin n_err++; $display("FAIL hyst_ctr01_target: got %h want 00003008", pred_target); end
      // taken, predicted not taken: ctr 01 -> 10
      set_ex(1'b1, 32'h0000_3004, BRANCH, 16'hFFFE, '0, '0, 1'b1, 32'h0000_3008);
      n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL hyst_t1_flush: got %0b want 1", flush); end
      tick();
      // taken, predicted taken: no flush, ctr 10 -> 11
      set_ex(1'b1, 32'h0000_3004, BRANCH, 16'hFFFE, '0, '0, 1'b1, 32'h0000_3000);
      n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL hyst_t2_flush: got %0b want 0", flush); end
      tick();
      clear_ex();
      // one not-taken from 11 leaves it at 10, still predicted taken
      set_ex(1'b1, 32'h0000_3004, BRANCH, 16'hFFFE, '0, '0, 1'b0, 32'h0000_3000);
      tick();
      clear_ex();
      seq_redirect(32'h0000_3004);
      n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL hyst_ctr11_taken: got %0b want 1", pred_taken); end
   endtask

   task automatic test_jump_jr();
      set_ex(1'b1, 32'h0000_3010, JUMP, '0, 26'h0000100, '0, 1'b0, 32'h0000_3014);
      n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL jump_flush: got %0b want 1", flush); end
      tick();
      clear_ex();
      n_cmp++; if (pc !== 32'h0000_0400) begin n_err++; $display("FAIL jump_pc: got %h want 00000400", pc); end
      seq_redirect(32'h0000_3010);
      n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL jump_btb_taken: got %0b want 1", pred_taken); end
      n_cmp++; if (pred_target !== 32'h0000_0400) begin n_err++; $display("FAIL jump_btb_target: got %h want 00000400", pred_target); end
      set_ex(1'b1, 32'h0000_3014, JR, '0, '0, 32'h0000_3020, 1'b0, 32'h0000_3018);
      n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL jr_flush: got %0b want 1", flush); end
      tick();
      clear_ex();
      n_cmp++; if (pc !== 32'h0000_3020) begin n_err++; $display("FAIL jr_pc: got %h want 00003020", pc); end
   endtask

   task automatic test_stall();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++; if (pc !== 32'h0000_3020) begin n_err++; $display("FAIL stall_hold%0d: got %h want 00003020", i, pc); end
      end
      set_ex(1'b1, 32'h0000_3100, SEQ, '0, '0, '0, 1'b0, 32'h0000_0000);
      n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL stall_redir_flush: got %0b want 1", flush); end
      tick();
      clear_ex();
      n_cmp++; if (pc !== 32'h0000_3104) begin n_err++; $display("FAIL stall_redir_pc: got %h want 00003104", pc); end
      stall = 1'b0;
   endtask

   task automatic test_aliasing();
      seq_redirect(32'h0000_3044);
      n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL alias_nohit: got %0b want 0", pred_taken); end
      n_cmp++; if (pred_target !== 32'h0000_3048) begin n_err++; $display("FAIL alias_target: got %h want 00003048", pred_target); end
      set_ex(1'b1, 32'h0000_3044, SEQ, '0, '0, '0, 1'b0, 32'h0000_3000);
      n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL alias_seq_flush: got %0b want 1", flush); end
      tick();
      clear_ex();
      n_cmp++; if (pc !== 32'h0000_3048) begin n_err++; $display("FAIL alias_seq_pc: got %h want 00003048", pc); end
      seq_redirect(32'h0000_3004);
      n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL alias_entry_kept: got %0b want 1", pred_taken); end
      n_cmp++; if (pred_target !== 32'h0000_3000) begin n_err++; $display("FAIL alias_entry_target: got %h want 00003000", pred_target); end
   endtask

   task automatic test_wrap();
      seq_redirect(32'hFFFF_FFFC);
      n_cmp++; if (pred_target !== 32'h0000_0000) begin n_err++; $display("FAIL wrap_target: got %h want 00000000", pred_target); end
      tick();
      n_cmp++; if (pc !== 32'h0000_0000) begin n_err++; $display("FAIL wrap_pc: got %h want 00000000", pc); end
   endtask

   task automatic test_mid_reset();
      seq_redirect(32'h0000_3004);
      n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL midrst_pre_taken: got %0b want 1", pred_taken); end
      rst = 1'b1;
      set_ex(1'b1, 32'h0000_3004, JUMP, '0, 26'h0000200, '0, 1'b0, 32'h0000_0000);
      n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL midrst_flush: got %0b want 0", flush); end
      n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL midrst_pred_taken: got %0b want 0", pred_taken); end
      tick();
      rst = 1'b0;
      clear_ex();
      n_cmp++; if (pc !== 32'h0000_3000) begin n_err++; $display("FAIL midrst_pc: got %h want 00003000", pc); end
      tick();
      n_cmp++; if (pc !== 32'h0000_3004) begin n_err++; $display("FAIL midrst_seq: got %h want 00003004", pc); end
      n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL midrst_btb_cleared: got %0b want 0", pred_taken); end
   endtask

   initial begin
      rst = 1'b1;
      stall = 1'b0;
      clear_ex();
      tick();
      test_reset();
      test_cold_branch();
      test_hysteresis();
      test_jump_jr();
      test_stall();
      test_aliasing();
      test_wrap();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/npc_predictor.md
# npc_predictor

Parametrised next-PC unit with a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters. It owns the architectural PC register in IF, predicts the next fetch address from the BTB, and resolves jump, branch and register-jump instructions in EX. On a mispredict it redirects fetch and flushes the front end, then trains the BTB. It replaces the purely combinational seq/jump/branch next-PC logic.

## Interface
- `WIDTH`, 32: address width; must be ≥ 32.
- `BTB_DEPTH`, 16: number of BTB entries; power of two, ≥ 2. `IDX = log2(BTB_DEPTH)`.
- `RESET_PC`, 32'h0000_3000: PC value loaded on reset.

Ports:
- `clk`  in  1  clock. One clock domain; everything updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `stall`  in  1  hold the PC; IF is not accepting a new fetch.
- `pc`  out  WIDTH  current fetch address, registered.
- `pred_taken`  out  1  the BTB predicts `pc` is taken (combinational).
- `pred_target`  out  WIDTH  predicted next PC: BTB target when `pred_taken`, otherwise `pc+4`.
- `ex_valid`  in  1  EX holds a real instruction (not a bubble).
- `ex_pc`  in  WIDTH  PC of the EX instruction.
- `ex_npc_op`  in  2  instruction class: 00 SEQ, 01 JUMP, 10 BRANCH, 11 JR.
- `ex_imm16`  in  16  branch offset.
- `ex_imm26`  in  26  jump index.
- `ex_reg_target`  in  WIDTH  register value used by JR.
- `ex_cond`  in  1  branch condition is true.
- `ex_pred_target`  in  WIDTH  `pred_target` that was piped along with this instruction.
- `flush`  out  1  squash IF/ID this cycle (combinational).

## Operation
- Address split:
  - BTB index = `pc[IDX+1:2]`.
  - Tag = `pc[WIDTH-1:IDX+2]`.
- Each BTB entry holds `valid`, `tag`, `target[WIDTH]` and `ctr[2]`.
- On reset, every `valid` is cleared. `tag`, `target` and `ctr` do not need a reset.
- IF lookup is an asynchronous read of the entry at `pc`'s index.
  - Hit = `valid` and tag match.
  - `pred_taken` = hit & `ctr[1]`.
- EX actual next PC (all arithmetic modulo 2^WIDTH), with `pc4` = `ex_pc+4`:
  - SEQ: `pc4`.
  - JUMP: `{pc4[WIDTH-1:28], imm26, 2'b00}`.
  - BRANCH: `pc4 + (sext(imm16) << 2)` when `ex_cond`; otherwise `pc4`.
  - JR: `ex_reg_target`.
- Mispredict = `ex_valid` and actual next PC ≠ `ex_pred_target`.
- `flush` = mispredict.
- Next-PC priority:
  1. `rst` → `RESET_PC`.
  2. Mispredict → actual next PC. Stall is ignored.
  3. `stall` → hold `pc`.
  4. Otherwise → `pred_target`.
- BTB training happens only when `ex_valid` and the class is not SEQ. The entry is indexed and tagged from `ex_pc`.
  - JUMP or JR: write `valid=1`, tag, target = actual next PC, `ctr=11`.
  - BRANCH taken, miss: allocate with target = branch target, `ctr=10`.
  - BRANCH taken, hit: `ctr` saturating +1, refresh the target.
  - BRANCH not taken, hit: `ctr` saturating −1. The target is unchanged.
  - BRANCH not taken, miss: no write.
- Training still happens when `stall` is asserted.
- SEQ instructions never write the BTB, even when they mispredict because of an aliased entry. The redirect alone corrects them.
- The aliasing case is expected: a SEQ instruction at an address whose tag collides in the BTB mispredicts on every visit.

## Timing
- PC latency is 1 cycle: the `pc` edge follows the next-PC selection of the previous cycle.
- The BTB write takes effect at the same edge. A lookup in that cycle sees the old contents; there is no write-through bypass.
- Redirect penalty: the mispredict is seen in EX in cycle N, `flush` is high in N, and the corrected `pc` appears in N+1.
- Reset: `pc` = `RESET_PC` from the edge that samples `rst`=1. While `rst` is high, `pred_taken`=0 and `flush`=0. The `ex_*` inputs are ignored and no training occurs.
- Reset mid-operation discards any pending redirect and clears the BTB.
- Simultaneous `stall` and mispredict: the redirect wins and `pc` updates.
- Wrap-around: `pc` = 2^WIDTH−4 with no hit gives a next PC of 0.

## Test plan
- Reset: pulse `rst` with `RESET_PC`=0x3000 → `pc`=0x3000, `pred_taken`=0. After three unstalled cycles, `pc`=0x300C.
- Cold branch: `ex_pc`=0x3004, BRANCH, `imm16`=0xFFFE, `ex_cond`=1, `ex_pred_target`=0x3008 → `flush`=1 and next `pc`=0x3000. The entry is allocated with `ctr`=10, so a later fetch of 0x3004 gives `pred_taken`=1, `pred_target`=0x3000.
- Counter hysteresis: that branch is not taken once → `flush`=1, `ctr`=01, and the next fetch gives `pred_taken`=0. Taken twice more → `ctr`=11.
- JUMP/JR: JUMP at 0x3010 with `imm26`=0x0000100 → target 0x0000_0400, redirect, entry written with `ctr`=11. JR with `ex_reg_target`=0x3020 → redirect to 0x3020.
- Stall vs redirect: `stall`=1 alone → `pc` held for 3 cycles. `stall`=1 together with a mispredict → `pc` takes the redirect target.
- Aliasing: with `BTB_DEPTH`=16, 0x3004 and 0x3044 share an index, so 0x3044 gives no hit (tag mismatch). A SEQ instruction whose `ex_pred_target` is wrong → `flush`=1, no BTB write.
